// File: rtl/bcd_to_bin_seq.sv
// Sequential packed-BCD to binary converter: one digit per clock, most significant
// digit first, acc = acc*10 + digit. Result and error flag are published with a done pulse.
module bcd_to_bin_seq #(
    parameter int DIGITS = 2,
    parameter int BIN_W  = 7
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [4*DIGITS-1:0] bcd_in,
    output logic                busy,
    output logic                done,
    output logic [BIN_W-1:0]    bin_out,
    output logic                err
);

    localparam int               CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(DIGITS - 1);

    typedef enum logic {IDLE, CONV} state_t;

    state_t              state_q, state_d;
    logic [4*DIGITS-1:0] sr_q, sr_d;
    logic [BIN_W-1:0]    acc_q, acc_d;
    logic [BIN_W-1:0]    bin_q, bin_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_acc_q, err_acc_d;
    logic                err_q, err_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [3:0]          digit;
    logic [BIN_W-1:0]    acc_next;
    logic                err_next;

    assign digit    = sr_q[4*DIGITS-1 -: 4];
    assign acc_next = (acc_q << 3) + (acc_q << 1) + BIN_W'(digit);
    assign err_next = err_acc_q | (digit > 4'd9);

    always_comb begin
        // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latch).
        state_d   = state_q;
        sr_d      = sr_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        err_acc_d = err_acc_q;
        bin_d     = bin_q;
        err_d     = err_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    sr_d      = bcd_in;
                    acc_d     = '0;
                    cnt_d     = '0;
                    err_acc_d = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = CONV;
                end
            end
            CONV: begin
                acc_d     = acc_next;
                sr_d      = sr_q << 4;
                err_acc_d = err_next;
                cnt_d     = cnt_q + CNT_W'(1);
                // Visible result only moves on the final digit edge, together with done.
                if (cnt_q == LAST) begin
                    bin_d   = acc_next;
                    err_d   = err_next;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the shift register is plain flops, not a memory, so it is reset like the rest.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sr_q      <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            err_acc_q <= 1'b0;
            bin_q     <= '0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values of the others.
            state_q   <= state_d;
            sr_q      <= sr_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            err_acc_q <= err_acc_d;
            bin_q     <= bin_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign bin_out = bin_q;
    assign err     = err_q;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Bench for bcd_to_bin_seq: a 2-digit instance checked every cycle against an arithmetic
// model, plus a 3-digit instance checked with directed literal expectations.
module tb_bcd_to_bin_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        start2 = 1'b0;
    logic [7:0]  bcd2 = 8'h00;
    logic        busy2, done2, err2;
    logic [6:0]  bin2;

    logic        start3 = 1'b0;
    logic [11:0] bcd3 = 12'h000;
    logic        busy3, done3, err3;
    logic [9:0]  bin3;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    bcd_to_bin_seq #(.DIGITS(2), .BIN_W(7)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .bcd_in(bcd2),
        .busy(busy2), .done(done2), .bin_out(bin2), .err(err2)
    );

    bcd_to_bin_seq #(.DIGITS(3), .BIN_W(10)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .bcd_in(bcd3),
        .busy(busy3), .done(done3), .bin_out(bin3), .err(err3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Value of a packed BCD word as a plain weighted digit sum (raw nibble values).
    function automatic int bcd_value(input logic [31:0] v, input int n);
        int s = 0;
        int p = 1;
        for (int i = 0; i < n; i++) begin
            s += int'(v[4*i +: 4]) * p;
            p *= 10;
        end
        return s;
    endfunction

    function automatic logic has_bad(input logic [31:0] v, input int n);
        logic b = 1'b0;
        for (int i = 0; i < n; i++)
            if (v[4*i +: 4] > 4'd9) b = 1'b1;
        return b;
    endfunction

    // Reference model for the 2-digit instance.
    logic       m_busy = 1'b0, m_done = 1'b0, m_err = 1'b0, m_perr = 1'b0;
    logic [6:0] m_bin = '0, m_pend = '0;
    int         m_left = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0; m_bin = '0; m_left = 0;
        end else begin
            m_done = 1'b0;
            if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                    m_bin  = m_pend;
                    m_err  = m_perr;
                end
            end else if (start2) begin
                m_busy = 1'b1;
                m_left = 2;
                m_pend = 7'(bcd_value(32'(bcd2), 2) % 128);
                m_perr = has_bad(32'(bcd2), 2);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("busy", 32'(busy2), 32'(m_busy));
            check("done", 32'(done2), 32'(m_done));
            check("bin_out", 32'(bin2), 32'(m_bin));
            check("err", 32'(err2), 32'(m_err));
        end
    end

    // Wait (bounded) for done on the 2-digit instance; returns the negedge count.
    task automatic wait_done2(output int n);
        n = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            n = i;
            if (done2) break;
        end
        check("done2_seen", 32'(done2), 32'd1);
    endtask

    // Called just after a rising edge with the instance idle; returns likewise.
    task automatic run2(input logic [7:0] v, input int eb, input logic ee);
        int n;
        start2 = 1'b1; bcd2 = v;
        @(posedge clk); #1;
        start2 = 1'b0; bcd2 = 8'hE7;
        wait_done2(n);
        check("lat2", 32'(n), 32'd3);
        check("bin2_lit", 32'(bin2), 32'(eb));
        check("err2_lit", 32'(err2), 32'(ee));
        @(posedge clk); #1;
    endtask

    task automatic run3(input logic [11:0] v, input int eb);
        int n = 0;
        start3 = 1'b1; bcd3 = v;
        @(posedge clk); #1;
        start3 = 1'b0; bcd3 = 12'hABC;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            n = i;
            if (i <= 3) check("busy3", 32'(busy3), 32'd1);
            if (done3) break;
        end
        check("done3_seen", 32'(done3), 32'd1);
        check("lat3", 32'(n), 32'd4);
        check("bin3_lit", 32'(bin3), 32'(eb));
        check("err3_lit", 32'(err3), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_busy", 32'(busy2), 32'd0);
            check("idle_bin", 32'(bin2), 32'd0);
        end
        @(posedge clk); #1;

        run2(8'h99, 99, 1'b0);
        run2(8'h00, 0, 1'b0);
        run2(8'h10, 10, 1'b0);
        run2(8'h4A, 50, 1'b1);
        run2(8'hFF, 37, 1'b1);
        run2(8'h25, 25, 1'b0);

        // Start held high: second word is picked up only on the done cycle.
        start2 = 1'b1; bcd2 = 8'h12;
        @(posedge clk); #1;
        bcd2 = 8'h34;
        wait_done2(n);
        check("hold_first", 32'(bin2), 32'd12);
        @(posedge clk); #1;
        start2 = 1'b0;
        wait_done2(n);
        check("hold_lat", 32'(n), 32'd3);
        check("hold_second", 32'(bin2), 32'd34);
        @(posedge clk); #1;

        // Reset mid-conversion clears outputs immediately and kills the done.
        start2 = 1'b1; bcd2 = 8'h87;
        @(posedge clk); #1;
        start2 = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("rst_busy", 32'(busy2), 32'd0);
        check("rst_done", 32'(done2), 32'd0);
        check("rst_bin", 32'(bin2), 32'd0);
        check("rst_err", 32'(err2), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("no_done_after_rst", 32'(done2), 32'd0);
        end
        @(posedge clk); #1;
        run2(8'h87, 87, 1'b0);

        // Idle with changing input: result must hold.
        for (int i = 0; i < 4; i++) begin
            bcd2 = 8'(8'h11 * (i + 1));
            @(posedge clk); #1;
        end
        check("idle_hold", 32'(bin2), 32'd87);

        run3(12'h255, 255);
        run3(12'h999, 999);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
